// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: requester count,
// select width, FSM state encoding and the rotating priority scan.
package rr_mux4_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arbState_e;

  // Returns the first asserted request found scanning ptr, ptr+1, ... with
  // natural 2-bit wrap. Callers only use the result when req is non-zero.
  function automatic logic [SEL_W-1:0] rrPick(input logic [NUM_REQ-1:0] req,
                                              input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester/downstream bundle for rr_mux4_arbiter. The master side drives
// requests, lock, data words and out_ready; the arbiter sits on the slave side.
interface rr_mux4_arbiter_if #(
  parameter int SIZE = 32
);
  import rr_mux4_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;
  logic [SIZE-1:0]    data0;
  logic [SIZE-1:0]    data1;
  logic [SIZE-1:0]    data2;
  logic [SIZE-1:0]    data3;
  logic [NUM_REQ-1:0] gnt;
  logic               out_valid;
  logic               out_ready;
  logic [SIZE-1:0]    out_data;
  logic [SEL_W-1:0]   out_src;

  modport master (
    output req, lock, data0, data1, data2, data3, out_ready,
    input  gnt, out_valid, out_data, out_src
  );

  modport slave (
    input  req, lock, data0, data1, data2, data3, out_ready,
    output gnt, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_mux4_arbiter_mux.sv
// Plain 4:1 word multiplexer used as the shared datapath of the arbiter.
module yMux4to1 #(
  parameter int SIZE = 32
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c
);

  // Select one of the four words by c.
  always_comb begin
    z = a0;
    case (c)
      2'd0: z = a0;
      2'd1: z = a1;
      2'd2: z = a2;
      2'd3: z = a3;
      default: z = a0;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a
// one-entry valid/ready output register and capped lock bursts.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  rr_mux4_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  arbState_e        state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burstCnt_q, burstCnt_d;
  logic             outValid_q;
  logic [SIZE-1:0]  outData_q;
  logic [SEL_W-1:0] outSrc_q;

  logic             accept;
  logic             anyReq;
  logic             grantEn;
  logic             ownerHolds;
  logic             ownerDropped;
  logic [SEL_W-1:0] scanPtr;
  logic [SEL_W-1:0] winner;
  logic [CNT_W-1:0] count;
  logic [SIZE-1:0]  muxZ;

  yMux4to1 #(.SIZE(SIZE)) uMux (
    .z  (muxZ),
    .a0 (bus.data0),
    .a1 (bus.data1),
    .a2 (bus.data2),
    .a3 (bus.data3),
    .c  (winner)
  );

  // Winner selection: a locked owner keeps the grant while requesting; an owner
  // that dropped its request is released and the scan restarts just past it.
  always_comb begin
    accept       = ~outValid_q | bus.out_ready;
    anyReq       = |bus.req;
    grantEn      = accept & anyReq & rst_n;
    ownerHolds   = (state_q == LOCK) &&  bus.req[owner_q];
    ownerDropped = (state_q == LOCK) && !bus.req[owner_q];
    scanPtr      = ownerDropped ? owner_q + SEL_W'(1) : ptr_q;
    winner       = ownerHolds ? owner_q : rrPick(bus.req, scanPtr);
    count        = ownerHolds ? burstCnt_q + CNT_W'(1) : CNT_W'(1);
    bus.gnt      = grantEn ? (GNT_ONE << winner) : '0;
  end

  // Next-state: stay locked only while the winner asks for it and the burst cap
  // is not reached; otherwise rotate priority past the winner.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    burstCnt_d = burstCnt_q;
    if (grantEn) begin
      if (bus.lock[winner] && (count < CNT_W'(MAX_BURST))) begin
        state_d    = LOCK;
        owner_d    = winner;
        burstCnt_d = count;
        ptr_d      = scanPtr;
      end else begin
        state_d    = ARB;
        ptr_d      = winner + SEL_W'(1);
        burstCnt_d = '0;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      burstCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      burstCnt_q <= burstCnt_d;
    end
  end

  // One-entry output register: load on a grant, empty when accepting with no
  // requests, hold everything under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSrc_q   <= '0;
    end else if (accept) begin
      if (anyReq) begin
        outValid_q <= 1'b1;
        outData_q  <= muxZ;
        outSrc_q   <= winner;
      end else begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_src   = outSrc_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural arbitration model.
module tb_rr_mux4_arbiter;

  localparam int SIZE      = 32;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_mux4_arbiter_if #(.SIZE(SIZE)) bus ();

  rr_mux4_arbiter #(.SIZE(SIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: priority pointer, locked owner (-1 = none), grant count
  // of the current burst, and the content of the output register.
  int              mPtr;
  int              mOwner;
  int              mBurst;
  logic            mValid;
  logic [SIZE-1:0] mData;
  logic [1:0]      mSrc;

  function automatic void modelReset();
    mPtr   = 0;
    mOwner = -1;
    mBurst = 0;
    mValid = 1'b0;
    mData  = '0;
    mSrc   = 2'd0;
  endfunction

  function automatic logic [SIZE-1:0] wordOf(input int idx);
    case (idx)
      0: return bus.data0;
      1: return bus.data1;
      2: return bus.data2;
      default: return bus.data3;
    endcase
  endfunction

  // Expected grant vector for the inputs currently driven.
  function automatic logic [3:0] modelGnt(output int win);
    int start;
    win = -1;
    if (rst_n !== 1'b1) return 4'b0000;
    if (mValid && !bus.out_ready) return 4'b0000;
    if (bus.req == 4'b0000) return 4'b0000;
    if (mOwner >= 0 && bus.req[mOwner]) begin
      win = mOwner;
    end else begin
      start = (mOwner >= 0) ? (mOwner + 1) % 4 : mPtr;
      for (int k = 0; k < 4; k++)
        if (win < 0 && bus.req[(start + k) % 4]) win = (start + k) % 4;
    end
    return 4'b0001 << win;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void modelCommit();
    int         win;
    int         grants;
    logic [3:0] g;
    g = modelGnt(win);
    if (mValid && !bus.out_ready) return;
    if (bus.req == 4'b0000) begin
      mValid = 1'b0;
      return;
    end
    if (g == 4'b0000) return;
    if (mOwner >= 0 && !bus.req[mOwner]) begin
      mPtr   = (mOwner + 1) % 4;
      mOwner = -1;
      mBurst = 0;
    end
    grants = (mOwner == win) ? mBurst + 1 : 1;
    mValid = 1'b1;
    mData  = wordOf(win);
    mSrc   = 2'(win);
    if (bus.lock[win] && grants < MAX_BURST) begin
      mOwner = win;
      mBurst = grants;
    end else begin
      mOwner = -1;
      mBurst = 0;
      mPtr   = (win + 1) % 4;
    end
  endfunction

  function automatic logic [SIZE+2:0] expOut();
    return {mValid, mSrc, mData};
  endfunction

  task automatic setData(input logic [SIZE-1:0] d0, input logic [SIZE-1:0] d1,
                         input logic [SIZE-1:0] d2, input logic [SIZE-1:0] d3);
    bus.data0 = d0;
    bus.data1 = d1;
    bus.data2 = d2;
    bus.data3 = d3;
  endtask

  // Drive one cycle's inputs shortly after a rising edge and let them settle.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    bus.req       = r;
    bus.lock      = l;
    bus.out_ready = rdy;
    #3;
  endtask

  task automatic advance();
    modelCommit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int         win;
    logic [3:0] expG;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_init_gnt: got %b expected 0000", bus.gnt);
    end
    checks++;
    if ({bus.out_valid, bus.out_src, bus.out_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_init_out: got v=%b src=%0d data=%h expected all zero",
               bus.out_valid, bus.out_src, bus.out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setData($urandom | 32'h8000_0000, $urandom | 32'h8000_0000,
              $urandom | 32'h8000_0000, $urandom | 32'h8000_0000);
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      expG = modelGnt(win);
      checks++;
      if (bus.gnt !== expG) begin
        errors++;
        $display("[TB] FAIL reset_pre_gnt cycle %0d: got %b expected %b", i, bus.gnt, expG);
      end
      advance();
    end
    rst_n = 1'b0;
    #1;
    modelReset();
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_gnt: got %b expected 0000", bus.gnt);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_src !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_out: got v=%b src=%0d data=%h expected all zero",
               bus.out_valid, bus.out_src, bus.out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    int         win;
    logic [3:0] expG;
    setData(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      expG = modelGnt(win);
      checks++;
      if (bus.gnt !== expG) begin
        errors++;
        $display("[TB] FAIL rotation_gnt cycle %0d: got %b expected %b", i, bus.gnt, expG);
      end
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== expOut()) begin
        errors++;
        $display("[TB] FAIL rotation_out cycle %0d: got %h expected %h", i,
                 {bus.out_valid, bus.out_src, bus.out_data}, expOut());
      end
      advance();
    end
  endtask

  task automatic test_single();
    int         win;
    logic [3:0] expG;
    for (int i = 0; i < 6; i++) begin
      setData($urandom, $urandom, $urandom, $urandom);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      checks++;
      if (bus.gnt !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL single_gnt cycle %0d: got %b expected 0100", i, bus.gnt);
      end
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== expOut()) begin
        errors++;
        $display("[TB] FAIL single_out cycle %0d: got %h expected %h", i,
                 {bus.out_valid, bus.out_src, bus.out_data}, expOut());
      end
      advance();
    end
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    expG = modelGnt(win);
    checks++;
    if (bus.gnt !== 4'b1000 || expG !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL single_wrap_gnt: got %b model %b expected 1000", bus.gnt, expG);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int         win;
    logic [3:0] expG;
    logic       rdy;
    for (int i = 0; i < 8; i++) begin
      rdy = (i == 0 || i > 3);
      setData($urandom, $urandom, $urandom, $urandom);
      applyStimulus(4'b1111, 4'b0000, rdy);
      expG = modelGnt(win);
      checks++;
      if (bus.gnt !== expG) begin
        errors++;
        $display("[TB] FAIL backpressure_gnt cycle %0d: got %b expected %b", i, bus.gnt, expG);
      end
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== expOut()) begin
        errors++;
        $display("[TB] FAIL backpressure_out cycle %0d: got %h expected %h", i,
                 {bus.out_valid, bus.out_src, bus.out_data}, expOut());
      end
      advance();
    end
  endtask

  task automatic test_burst();
    logic [3:0] expTab [6];
    expTab = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    setData(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    advance();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1111, 4'b0010, 1'b1);
      checks++;
      if (bus.gnt !== expTab[i]) begin
        errors++;
        $display("[TB] FAIL burst_gnt cycle %0d: got %b expected %b", i, bus.gnt, expTab[i]);
      end
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== expOut()) begin
        errors++;
        $display("[TB] FAIL burst_out cycle %0d: got %h expected %h", i,
                 {bus.out_valid, bus.out_src, bus.out_data}, expOut());
      end
      advance();
    end
  endtask

  task automatic test_owner_drop();
    logic [3:0] reqTab  [6];
    logic [3:0] lockTab [6];
    logic [3:0] expTab  [6];
    reqTab  = '{4'b1111, 4'b1111, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
    lockTab = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    expTab  = '{4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    setData(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    advance();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(reqTab[i], lockTab[i], 1'b1);
      checks++;
      if (bus.gnt !== expTab[i]) begin
        errors++;
        $display("[TB] FAIL drop_gnt cycle %0d: got %b expected %b", i, bus.gnt, expTab[i]);
      end
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== expOut()) begin
        errors++;
        $display("[TB] FAIL drop_out cycle %0d: got %h expected %h", i,
                 {bus.out_valid, bus.out_src, bus.out_data}, expOut());
      end
      advance();
    end
  endtask

  task automatic test_random();
    int         win;
    logic [3:0] expG;
    logic [3:0] r;
    logic [3:0] l;
    logic       rdy;
    for (int i = 0; i < 400; i++) begin
      r   = 4'($urandom_range(0, 15));
      l   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 9) < 7);
      setData($urandom, $urandom, $urandom, $urandom);
      applyStimulus(r, l, rdy);
      expG = modelGnt(win);
      checks++;
      if (bus.gnt !== expG) begin
        errors++;
        $display("[TB] FAIL random_gnt cycle %0d: got %b expected %b (req=%b lock=%b rdy=%b)",
                 i, bus.gnt, expG, r, l, rdy);
      end
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== expOut()) begin
        errors++;
        $display("[TB] FAIL random_out cycle %0d: got %h expected %h", i,
                 {bus.out_valid, bus.out_src, bus.out_data}, expOut());
      end
      advance();
    end
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req       = 4'b0000;
    bus.lock      = 4'b0000;
    bus.out_ready = 1'b0;
    setData('0, '0, '0, '0);
    modelReset();
    #1;
    test_reset();
    test_rotation();
    test_single();
    test_backpressure();
    test_burst();
    test_owner_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
